// File: rtl/fu_mult.sv
// fu_mult: four-stage pipelined RV32M multiply unit (16 multiplier bits per stage)
package fu_mult_pkg;
  localparam int XLEN = 32;
  localparam int PR_W = 6;
  localparam int ROB_W = 5;
  typedef enum logic [1:0] {MULT, MULH, MULHSU, MULHU} mult_func_t;
  typedef struct packed {
    mult_func_t mult;
  } op_sel_t;
  typedef struct packed {
    logic             valid;
    op_sel_t          op_sel;
    logic [XLEN-1:0]  r1_value;
    logic [XLEN-1:0]  r2_value;
    logic [PR_W-1:0]  dest_pr;
    logic [ROB_W-1:0] rob_entry;
  } ISSUE_FU_PACKET;
  typedef struct packed {
    logic             valid;
    logic [PR_W-1:0]  dest_pr;
    logic [ROB_W-1:0] rob_entry;
    logic [XLEN-1:0]  dest_value;
  } FU_COMPLETE_PACKET;
  typedef struct packed {
    logic             valid;
    mult_func_t       op;
    logic [PR_W-1:0]  dest_pr;
    logic [ROB_W-1:0] rob_entry;
  } tag_t;
endpackage

module fu_mult
  import fu_mult_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              complete_stall,
  input  ISSUE_FU_PACKET    fu_packet_in,
  output logic              fu_ready,
  output logic              want_to_complete,
  output FU_COMPLETE_PACKET fu_packet_out
);
  tag_t        tag [4];
  logic [63:0] sum [4];
  logic [63:0] mc [3];
  logic [47:0] mp1;
  logic [31:0] mp2;
  logic [15:0] mp3;
  logic [63:0] a, b;
  logic        adv;
  mult_func_t  f;
  assign f = fu_packet_in.op_sel.mult;
  assign a = {{32{f != MULHU && fu_packet_in.r1_value[31]}}, fu_packet_in.r1_value};
  assign b = {{32{(f == MULT || f == MULH) && fu_packet_in.r2_value[31]}}, fu_packet_in.r2_value};
  assign want_to_complete = tag[3].valid;
  assign adv = ~(want_to_complete & complete_stall);
  assign fu_ready = adv;
  // the remaining multiplier shrinks 16 bits per stage, so only live bits are stored
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      for (int i = 0; i < 4; i++) begin
        tag[i] <= '0;
        sum[i] <= '0;
      end
      for (int i = 0; i < 3; i++) mc[i] <= '0;
      mp1 <= '0;
      mp2 <= '0;
      mp3 <= '0;
    end else if (adv) begin
      tag[0] <= '{valid: fu_packet_in.valid, op: f, dest_pr: fu_packet_in.dest_pr,
                  rob_entry: fu_packet_in.rob_entry};
      for (int i = 1; i < 4; i++) tag[i] <= tag[i-1];
      sum[0] <= a * 64'(b[15:0]);
      sum[1] <= sum[0] + mc[0] * 64'(mp1[15:0]);
      sum[2] <= sum[1] + mc[1] * 64'(mp2[15:0]);
      sum[3] <= sum[2] + mc[2] * 64'(mp3);
      mc[0] <= a << 16;
      mc[1] <= mc[0] << 16;
      mc[2] <= mc[1] << 16;
      mp1 <= b[63:16];
      mp2 <= mp1[47:16];
      mp3 <= mp2[31:16];
    end
  assign fu_packet_out = '{valid: want_to_complete, dest_pr: tag[3].dest_pr,
                           rob_entry: tag[3].rob_entry,
                           dest_value: tag[3].op == MULT ? sum[3][31:0] : sum[3][63:32]};
endmodule

// File: tb/tb_fu_mult.sv
// tb_fu_mult: directed and random scoreboard bench for fu_mult
module tb_fu_mult;
  import fu_mult_pkg::*;
  typedef struct packed {
    logic [PR_W-1:0]  pr;
    logic [ROB_W-1:0] rob;
    logic [31:0]      val;
  } exp_t;
  logic              clock = 0;
  logic              reset = 0;
  logic              complete_stall = 0;
  ISSUE_FU_PACKET    fu_packet_in;
  logic              fu_ready, want_to_complete;
  FU_COMPLETE_PACKET fu_packet_out, snap;
  exp_t              q[$];
  exp_t              pend, e;
  int                passed = 0, total = 0, done = 0, done_mark = 0;

  fu_mult dut (
    .clock(clock), .reset(reset), .complete_stall(complete_stall),
    .fu_packet_in(fu_packet_in), .fu_ready(fu_ready),
    .want_to_complete(want_to_complete), .fu_packet_out(fu_packet_out)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", name, obs, exp);
  endtask

  function automatic logic [31:0] model(input mult_func_t f, input logic [31:0] x, input logic [31:0] y);
    longint sx = $signed(x);
    longint sy = $signed(y);
    longint ux = {32'b0, x};
    longint uy = {32'b0, y};
    longint p = ((f == MULHU) ? ux : sx) * ((f == MULT || f == MULH) ? sy : uy);
    logic [63:0] pv = p;
    return (f == MULT) ? pv[31:0] : pv[63:32];
  endfunction

  // scoreboard: pop on consumption, push on acceptance
  always @(negedge clock) begin
    if (want_to_complete && !complete_stall) begin
      done++;
      if (q.size() == 0) chk("unexpected completion", 64'd1, 64'd0);
      else begin
        e = q.pop_front();
        chk("completion", 64'(fu_packet_out), 64'({1'b1, e.pr, e.rob, e.val}));
      end
    end
    if (fu_packet_in.valid && fu_ready && reset) q.push_back(pend);
  end

  task automatic issue(input mult_func_t f, input logic [31:0] x, input logic [31:0] y,
                       input logic [PR_W-1:0] pr, input logic [ROB_W-1:0] rob, input logic [31:0] ev);
    int n = 0;
    pend = '{pr: pr, rob: rob, val: ev};
    fu_packet_in = '{valid: 1'b1, op_sel: '{mult: f}, r1_value: x, r2_value: y,
                     dest_pr: pr, rob_entry: rob};
    @(negedge clock);
    while (!fu_ready && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (n == 50) chk("issue timeout", 64'd1, 64'd0);
    @(posedge clock);
    #1 fu_packet_in.valid = 1'b0;
  endtask

  task automatic issue_rand(input int i);
    mult_func_t f = mult_func_t'($urandom_range(0, 3));
    logic [31:0] x = $urandom;
    logic [31:0] y = $urandom;
    issue(f, x, y, PR_W'(i), ROB_W'(i + 3), model(f, x, y));
  endtask

  initial begin
    #200000;
    $display("FAIL global timeout");
    $fatal(1);
  end

  initial begin
    fu_packet_in = '0;
    pend = '0;
    #2;
    chk("reset want", 64'(want_to_complete), 64'd0);
    chk("reset ready", 64'(fu_ready), 64'd1);
    chk("reset out valid", 64'(fu_packet_out.valid), 64'd0);
    @(negedge clock);
    reset = 1;
    @(posedge clock);
    #1;
    issue(MULT, 32'd7, 32'd5, 6'd1, 5'd2, 32'h00000023);
    repeat (3) begin
      @(negedge clock);
      chk("latency early", 64'(want_to_complete), 64'd0);
    end
    @(negedge clock);
    chk("latency", 64'(want_to_complete), 64'd1);
    @(posedge clock);
    #1;
    issue(MULH,   32'hFFFFFFFE, 32'd3,        6'd10, 5'd11, 32'hFFFFFFFF);
    issue(MULHSU, 32'hFFFFFFFF, 32'h0000FFFF, 6'd12, 5'd13, 32'hFFFFFFFF);
    issue(MULHU,  32'hFFFF0000, 32'h0000FFFF, 6'd14, 5'd15, 32'h0000FFFE);
    issue(MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 6'd16, 5'd17, 32'hFFFFFFFE);
    issue(MULT,   32'hFFFFFFFF, 32'hFFFFFFFF, 6'd18, 5'd19, 32'h00000001);
    repeat (6) @(posedge clock);
    #1 chk("directed drained", 64'(q.size()), 64'd0);
    for (int i = 0; i < 8; i++) issue_rand(20 + i);
    repeat (6) @(posedge clock);
    #1 chk("random drained", 64'(q.size()), 64'd0);
    done_mark = done;
    for (int i = 0; i < 4; i++) issue_rand(40 + i);
    complete_stall = 1;
    pend = '{pr: 6'd50, rob: 5'd21, val: model(MULHSU, 32'h80000000, 32'h00000002)};
    fu_packet_in = '{valid: 1'b1, op_sel: '{mult: MULHSU}, r1_value: 32'h80000000,
                     r2_value: 32'h00000002, dest_pr: 6'd50, rob_entry: 5'd21};
    @(negedge clock);
    snap = fu_packet_out;
    chk("stall ready", 64'(fu_ready), 64'd0);
    repeat (2) begin
      @(negedge clock);
      chk("stall ready", 64'(fu_ready), 64'd0);
      chk("stall frozen", 64'(fu_packet_out), 64'(snap));
    end
    @(posedge clock);
    #1 complete_stall = 0;
    @(posedge clock);
    #1 fu_packet_in.valid = 1'b0;
    repeat (8) @(posedge clock);
    #1 chk("stall drained", 64'(q.size()), 64'd0);
    chk("stall count", 64'(done - done_mark), 64'd5);
    for (int i = 0; i < 3; i++) issue_rand(60 + i);
    @(posedge clock);
    #1 complete_stall = 1;
    #1 chk("pre-reset want", 64'(want_to_complete), 64'd1);
    #1 reset = 0;
    #1;
    chk("async reset want", 64'(want_to_complete), 64'd0);
    chk("async reset ready", 64'(fu_ready), 64'd1);
    chk("async reset out valid", 64'(fu_packet_out.valid), 64'd0);
    q.delete();
    done_mark = done;
    @(posedge clock);
    #1;
    complete_stall = 0;
    reset = 1;
    repeat (10) @(posedge clock);
    #1 chk("no stale completion", 64'(done - done_mark), 64'd0);
    issue(MULT, 32'd3, 32'd4, 6'd33, 5'd9, 32'd12);
    repeat (6) @(posedge clock);
    #1 chk("post-reset drained", 64'(q.size()), 64'd0);
    chk("post-reset count", 64'(done - done_mark), 64'd1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
